// File: rtl/matrix_pkg.sv
// Shared constants and types for the 5x7 LED matrix frame buffer and its helpers.
package matrix_pkg;

  localparam int NUM_COLUMNS   = 5;
  localparam int ROW_BITS      = 7;
  localparam int COL_ADDR_BITS = 3;

  typedef logic [ROW_BITS-1:0]      column_t;
  typedef logic [COL_ADDR_BITS-1:0] col_addr_t;

  typedef enum logic {
    IDLE,
    PENDING
  } commit_state_t;

endpackage

// File: rtl/matrix_frame_buffer_if.sv
// Write/commit/display bus between frame-buffer control logic and the frame buffer.
interface matrix_frame_buffer_if;
  import matrix_pkg::*;

  logic      wr_en;
  col_addr_t wr_addr;
  column_t   wr_data;
  logic      wr_ready;
  logic      commit;
  logic      pending;
  logic      commit_done;
  logic      frame_tick;
  logic      blink_en;
  column_t   column_0;
  column_t   column_1;
  column_t   column_2;
  column_t   column_3;
  column_t   column_4;

  modport master (
    output wr_en, wr_addr, wr_data, commit, frame_tick, blink_en,
    input  wr_ready, pending, commit_done,
    input  column_0, column_1, column_2, column_3, column_4
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, frame_tick, blink_en,
    output wr_ready, pending, commit_done,
    output column_0, column_1, column_2, column_3, column_4
  );

endinterface

// File: rtl/matrix_blink_timer.sv
// Frame-counted blink phase: toggles every BLINK_FRAMES frame ticks while enabled.
module matrix_blink_timer #(
  parameter int BLINK_FRAMES = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic frame_tick,
  input  logic blink_en,
  output logic phase_on
);

  localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

  logic [7:0] frame_cnt;

  // Counter and phase only move on frame ticks, so every toggle is frame aligned.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (!blink_en) begin
      frame_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (frame_tick) begin
      if (frame_cnt == LAST_FRAME) begin
        frame_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/matrix_frame_buffer.sv
// Double-buffered 5x7 LED frame: edits go to the back frame and are copied to the
// displayed front frame only on a scan-frame boundary, so the display never tears.
module matrix_frame_buffer
  import matrix_pkg::*;
#(
  parameter int BLINK_FRAMES = 50
) (
  input  logic                  clock,
  input  logic                  reset,
  matrix_frame_buffer_if.slave  bus
);

  commit_state_t state;
  column_t       front [NUM_COLUMNS];
  column_t       back  [NUM_COLUMNS];
  logic          commit_done_r;
  logic          phase_on;
  logic          write_ok;

  // Writes are refused while a commit waits, so the copied frame is exactly what was committed.
  assign write_ok = bus.wr_en && (state == IDLE) &&
                    (bus.wr_addr < COL_ADDR_BITS'(NUM_COLUMNS));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_COLUMNS; k++) back[k] <= '0;
    end else if (write_ok) begin
      back[bus.wr_addr] <= bus.wr_data;
    end
  end

  // A commit seen together with a frame tick only arms; the copy waits for the next tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      commit_done_r <= 1'b0;
      for (int k = 0; k < NUM_COLUMNS; k++) front[k] <= '0;
    end else begin
      commit_done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.commit) state <= PENDING;
        end
        PENDING: begin
          if (bus.frame_tick) begin
            front         <= back;
            commit_done_r <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  matrix_blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink_timer (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (bus.frame_tick),
    .blink_en   (bus.blink_en),
    .phase_on   (phase_on)
  );

  assign bus.pending     = (state == PENDING);
  assign bus.wr_ready    = (state == IDLE);
  assign bus.commit_done = commit_done_r;

  // Blanking gates only the outputs; the front frame itself is untouched.
  assign bus.column_0 = phase_on ? front[0] : '0;
  assign bus.column_1 = phase_on ? front[1] : '0;
  assign bus.column_2 = phase_on ? front[2] : '0;
  assign bus.column_3 = phase_on ? front[3] : '0;
  assign bus.column_4 = phase_on ? front[4] : '0;

endmodule

// File: tb/tb_matrix_frame_buffer.sv
// Directed bench for matrix_frame_buffer with a cycle-level reference model and literal checks.
module tb_matrix_frame_buffer;
  import matrix_pkg::*;

  localparam int BF = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_frame_buffer_if bus ();

  matrix_frame_buffer #(
    .BLINK_FRAMES (BF)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  logic [6:0] m_front [5];
  logic [6:0] m_back  [5];
  bit         m_pending;
  bit         m_done;
  bit         m_phase;
  int         m_cnt;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_col(int k);
    case (k)
      0:       return bus.column_0;
      1:       return bus.column_1;
      2:       return bus.column_2;
      3:       return bus.column_3;
      default: return bus.column_4;
    endcase
  endfunction

  // Reference model: frame copy on boundary, blink phase as a frame count
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 5; k++) begin
        m_front[k] = '0;
        m_back[k]  = '0;
      end
      m_pending = 0;
      m_done    = 0;
      m_phase   = 1;
      m_cnt     = 0;
    end else begin
      int a;
      a      = int'(bus.wr_addr);
      m_done = 0;
      if (m_pending) begin
        if (bus.frame_tick) begin
          for (int k = 0; k < 5; k++) m_front[k] = m_back[k];
          m_done    = 1;
          m_pending = 0;
        end
      end else begin
        if (bus.wr_en && a < 5) m_back[a] = bus.wr_data;
        if (bus.commit) m_pending = 1;
      end
      if (!bus.blink_en) begin
        m_cnt   = 0;
        m_phase = 1;
      end else if (bus.frame_tick) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == BF) begin
          m_cnt   = 0;
          m_phase = !m_phase;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_on) begin
      for (int k = 0; k < 5; k++)
        check($sformatf("model_col%0d", k), int'(dut_col(k)),
              m_phase ? int'(m_front[k]) : 0);
      check("model_pending", int'(bus.pending), int'(m_pending));
      check("model_wr_ready", int'(bus.wr_ready), int'(!m_pending));
      check("model_commit_done", int'(bus.commit_done), int'(m_done));
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(int a, int d, bit c = 1'b0);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[2:0];
    bus.wr_data = d[6:0];
    bus.commit  = c;
    cyc();
    bus.wr_en   = 1'b0;
    bus.commit  = 1'b0;
  endtask

  task automatic pulse_commit();
    bus.commit = 1'b1;
    cyc();
    bus.commit = 1'b0;
  endtask

  task automatic raise_tick();
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    bus.wr_en      = 1'b1;
    bus.wr_addr    = 3'd0;
    bus.wr_data    = 7'h7F;
    bus.commit     = 1'b0;
    bus.frame_tick = 1'b0;
    bus.blink_en   = 1'b0;

    // Reset held low during a write
    cyc(3);
    check("rst_col0", int'(bus.column_0), 0);
    check("rst_pending", int'(bus.pending), 0);
    check("rst_wr_ready", int'(bus.wr_ready), 1);
    bus.wr_en = 1'b0;
    rst_n     = 1'b1;
    cmp_on    = 1'b1;
    cyc(2);
    check("post_rst_col0", int'(bus.column_0), 0);

    // Walking-one columns, commit, boundary 20 cycles later
    for (int k = 0; k < 5; k++) wr(k, 1 << k);
    for (int k = 0; k < 5; k++) check($sformatf("precommit_col%0d", k), int'(dut_col(k)), 0);
    pulse_commit();
    for (int i = 0; i < 20; i++) begin
      check("wait_pending", int'(bus.pending), 1);
      cyc();
    end
    raise_tick();
    check("t2_commit_done", int'(bus.commit_done), 1);
    check("t2_col0", int'(bus.column_0), 'h01);
    check("t2_col1", int'(bus.column_1), 'h02);
    check("t2_col2", int'(bus.column_2), 'h04);
    check("t2_col3", int'(bus.column_3), 'h08);
    check("t2_col4", int'(bus.column_4), 'h10);
    cyc();
    check("t2_done_one_cycle", int'(bus.commit_done), 0);

    // Write and second commit while pending are both dropped
    pulse_commit();
    cyc(2);
    check("t3_wr_ready", int'(bus.wr_ready), 0);
    wr(2, 'h7F);
    pulse_commit();
    cyc(2);
    raise_tick();
    check("t3_col2", int'(bus.column_2), 'h04);
    cyc(3);
    check("t3_no_requeue", int'(bus.pending), 0);

    // Commit coincident with frame tick only arms
    wr(0, 'h11);
    bus.commit     = 1'b1;
    bus.frame_tick = 1'b1;
    cyc();
    bus.commit     = 1'b0;
    bus.frame_tick = 1'b0;
    check("t4_pending", int'(bus.pending), 1);
    check("t4_no_done", int'(bus.commit_done), 0);
    check("t4_col0_old", int'(bus.column_0), 'h01);
    cyc(3);
    raise_tick();
    check("t4_done", int'(bus.commit_done), 1);
    check("t4_col0_new", int'(bus.column_0), 'h11);

    // Out-of-range address, then write in the commit cycle
    wr(6, 'h55);
    pulse_commit();
    cyc();
    raise_tick();
    check("t5_col0", int'(bus.column_0), 'h11);
    check("t5_col1", int'(bus.column_1), 'h02);
    check("t5_col2", int'(bus.column_2), 'h04);
    check("t5_col3", int'(bus.column_3), 'h08);
    check("t5_col4", int'(bus.column_4), 'h10);
    wr(3, 'h3C, 1'b1);
    cyc(2);
    raise_tick();
    check("t5_col3_new", int'(bus.column_3), 'h3C);

    // Blink with BLINK_FRAMES = 2: blank after ticks 2,6, restored after 4
    bus.blink_en = 1'b1;
    cyc(2);
    for (int t = 1; t <= 6; t++) begin
      raise_tick();
      check($sformatf("blink_tick%0d", t), int'(bus.column_0), ((t / 2) % 2) ? 0 : 'h11);
      cyc(2);
      check($sformatf("blink_hold%0d", t), int'(bus.column_0), ((t / 2) % 2) ? 0 : 'h11);
    end
    bus.blink_en = 1'b0;
    cyc();
    check("blink_off_col0", int'(bus.column_0), 'h11);
    check("blink_off_col3", int'(bus.column_3), 'h3C);

    // Reset while a commit is pending discards it
    wr(1, 'h7E);
    pulse_commit();
    cyc(2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_pending", int'(bus.pending), 0);
    check("rst_mid_col3", int'(bus.column_3), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    raise_tick();
    check("rst_mid_no_done", int'(bus.commit_done), 0);
    check("rst_mid_col1", int'(bus.column_1), 0);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
